// File: rtl/mac_fp16_feeder.sv
// mac_fp16_feeder: operand sequencer for the FP16 MAC stage.
// Buffers (A, B, last) pairs from a valid/ready stream and launches one pair
// per cycle onto the MAC inputs. It clears the MAC before each vector, waits
// out the MAC pipeline latency after the last pair, and returns the final
// accumulator value on a result handshake.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   in_valid/in_ready         input pair handshake
//   in_a, in_b, in_last       FP16 operands and end-of-vector marker
//   mac_a, mac_b              registered operands to the MAC
//   mac_rst                   registered active-high MAC clear
//   mac_acc                   MAC accumulator output
//   res_valid/res_ready       result handshake
//   res_data                  captured accumulator value
//   busy                      high in CLEAR, DRAIN and HOLD
module mac_fp16_feeder #(
  parameter int unsigned LATENCY    = 7,
  parameter int unsigned CLR_CYCLES = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic        mac_rst,
  input  logic [15:0] mac_acc,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_MAX = (LATENCY > CLR_CYCLES) ? LATENCY : CLR_CYCLES;
  localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

  typedef struct packed {
    logic        last;
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;

  pair_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt_c;
  logic             push_c;
  logic             pop_c;
  logic             empty_c;
  pair_t            head_c;

  // in_ready is a register that always mirrors !full, so a pop never lets a
  // full FIFO accept in the same cycle.
  assign push_c  = in_valid && in_ready;
  assign empty_c = (count == '0);
  assign pop_c   = (state == S_FEED) && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Occupancy after this edge.
  always_comb begin
    count_nxt_c = count;
    unique case ({push_c, pop_c})
      2'b10:   count_nxt_c = count + CNT_W'(1);
      2'b01:   count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
  end

  // FIFO storage; contents need no reset, pointers guard validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{last: in_last, a: in_a, b: in_b};
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_nxt_c;
      in_ready <= (count_nxt_c != CNT_W'(FIFO_DEPTH));
    end
  end

  // Sequencer: clear MAC, feed a vector, wait out latency, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      timer     <= TMR_W'(CLR_CYCLES);
      mac_a     <= '0;
      mac_b     <= '0;
      mac_rst   <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b1;
    end else begin
      // Zero operands whenever nothing is launched; a zero product is a no-op.
      mac_a <= '0;
      mac_b <= '0;
      unique case (state)
        S_CLEAR: begin
          if (timer == TMR_W'(1)) begin
            mac_rst <= 1'b0;
            busy    <= 1'b0;
            state   <= S_FEED;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_FEED: begin
          if (pop_c) begin
            mac_a <= head_c.a;
            mac_b <= head_c.b;
            if (head_c.last) begin
              timer <= TMR_W'(LATENCY);
              busy  <= 1'b1;
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (timer == TMR_W'(1)) begin
            res_data  <= mac_acc;
            res_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            timer     <= TMR_W'(CLR_CYCLES);
            mac_rst   <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        default: begin
          state   <= S_CLEAR;
          timer   <= TMR_W'(CLR_CYCLES);
          mac_rst <= 1'b1;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_fp16_feeder.sv
// Self-checking bench for mac_fp16_feeder: behavioural FP16 MAC with a fixed
// latency drives mac_acc; a negedge monitor predicts launches, FIFO fullness,
// result timing and dot-product values from the pushed pairs.
module tb_mac_fp16_feeder;

  localparam int unsigned LATENCY    = 7;
  localparam int unsigned CLR_CYCLES = 5;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          MAXP       = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_rst;
  logic [15:0] mac_acc;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic stim_done;

  logic [15:0] tbl [8] = '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00,
                           16'hBE00, 16'h4200, 16'hC000, 16'h3400};

  mac_fp16_feeder #(
    .LATENCY(LATENCY), .CLR_CYCLES(CLR_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_rst(mac_rst), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin
      v = real'(h[9:0]);
      e = -24;
    end else begin
      v = real'({1'b1, h[9:0]});
      e = e - 25;
    end
    while (e > 0) begin v = v * 2.0; e = e - 1; end
    while (e < 0) begin v = v / 2.0; e = e + 1; end
    return h[15] ? -v : v;
  endfunction

  // Exact for the operand sets used here (small dyadic values).
  function automatic logic [15:0] r2h(input real r);
    real  a;
    int   e;
    int   m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e = e + 1; end
    while (a < 1.0)  begin a = a * 2.0; e = e - 1; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e = e + 1; end
    return {s, 5'(e), 10'(m)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural MAC: accumulate at each edge, result visible LATENCY edges
  // after launch.
  logic [15:0] acc_pipe [LATENCY-1];
  always @(posedge clk) begin
    acc_pipe[0] <= mac_rst ? 16'h0000
                 : r2h(h2r(acc_pipe[0]) + h2r(mac_a) * h2r(mac_b));
    for (int i = 1; i < LATENCY - 1; i++) acc_pipe[i] <= acc_pipe[i-1];
  end
  assign mac_acc = acc_pipe[LATENCY-2];

  // Reference state owned by the monitor.
  logic [15:0] pa [MAXP];
  logic [15:0] pb [MAXP];
  logic        plast [MAXP];
  int          pcyc [MAXP];
  logic [15:0] exp_res [MAXP];
  int   pwr, prd, ewr, erd;
  int   cyc, last_cyc, clr_run;
  real  vsum;
  logic exp_launch, exp_launch_nxt, clr_arm;
  logic prev_rv, prev_rr;
  logic [15:0] prev_data;

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pwr = 0; prd = 0; ewr = 0; erd = 0;
        vsum = 0.0; exp_launch = 1'b0; clr_arm = 1'b0; clr_run = 0;
        prev_rv = 1'b0; prev_rr = 1'b0; prev_data = '0; last_cyc = 0;
      end else begin
        exp_launch_nxt = 1'b0;
        if (exp_launch) check("throughput", 32'(mac_a != 0 || mac_b != 0), 32'd1);
        if (mac_a != 0 || mac_b != 0) begin
          if (prd >= pwr) begin
            check("spurious_launch", {mac_a, mac_b}, 32'd0);
          end else begin
            check("launch_pair", {mac_a, mac_b}, {pa[prd], pb[prd]});
            check("launch_lat", 32'(cyc - pcyc[prd] >= 2), 32'd1);
            check("busy_feed", 32'(busy), 32'(plast[prd]));
            if (plast[prd]) last_cyc = cyc;
            else if (pwr > prd + 1) exp_launch_nxt = 1'b1;
            prd++;
          end
        end
        check("in_ready", 32'(in_ready), 32'((pwr - prd) < FIFO_DEPTH));
        if (res_valid && !prev_rv) check("res_lat", 32'(cyc - last_cyc), 32'(LATENCY));
        if (prev_rv && !prev_rr) begin
          check("hold_valid", 32'(res_valid), 32'd1);
          check("hold_data", 32'(res_data), 32'(prev_data));
          check("hold_busy", 32'(busy), 32'd1);
        end
        if (clr_arm) begin
          if (mac_rst) clr_run++;
          else begin
            check("clr_len", 32'(clr_run), 32'(CLR_CYCLES));
            clr_arm = 1'b0;
          end
        end
        if (res_valid && res_ready) begin
          if (erd < ewr) begin
            check("res_data", 32'(res_data), 32'(exp_res[erd]));
            erd++;
          end else begin
            check("spurious_res", 32'(res_valid), 32'd0);
          end
          clr_arm = 1'b1;
          clr_run = 0;
        end
        if (in_valid && in_ready) begin
          pa[pwr] = in_a; pb[pwr] = in_b; plast[pwr] = in_last; pcyc[pwr] = cyc;
          vsum = vsum + h2r(in_a) * h2r(in_b);
          if (in_last) begin
            exp_res[ewr] = r2h(vsum);
            ewr++;
            vsum = 0.0;
          end
          pwr++;
        end
        exp_launch = exp_launch_nxt;
        prev_rv = res_valid; prev_rr = res_ready; prev_data = res_data;
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic last);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && erd != ewr; i++) begin @(negedge clk); #2; end
    check("results_done", 32'(erd), 32'(ewr));
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mac_a"}, 32'(mac_a), 32'd0);
    check({tag, "_mac_b"}, 32'(mac_b), 32'd0);
    check({tag, "_mac_rst"}, 32'(mac_rst), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    res_ready = 1'b1; stim_done = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    release_reset();

    // Two-element vector: 1*1 + 2*2 = 5.
    push(16'h3C00, 16'h3C00, 1'b0);
    push(16'h4000, 16'h4000, 1'b1);
    wait_idle();

    // Result held while the consumer stalls: -1.5*2 = -3.
    res_ready = 1'b0;
    push(16'hBE00, 16'h4000, 1'b1);
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
    check("t2_valid", 32'(res_valid), 32'd1);
    idle(10);
    check("t2_data", 32'(res_data), 32'h0000_C200);
    res_ready = 1'b1;
    wait_idle();

    // Four back-to-back pairs: 4.0.
    for (int i = 0; i < 4; i++) push(16'h3C00, 16'h3C00, 1'(i == 3));
    wait_idle();

    // Input gaps must launch nothing: 1 + 5*0 + 1 = 2.
    push(16'h3C00, 16'h3C00, 1'b0);
    idle(3);
    push(16'h4500, 16'h0000, 1'b0);
    idle(1);
    push(16'h3C00, 16'h3C00, 1'b1);
    wait_idle();

    // Back-pressure: buffer fills while a result is held.
    res_ready = 1'b0;
    fork
      begin
        push(16'h3C00, 16'h3C00, 1'b0);
        push(16'h4000, 16'h4000, 1'b1);
        push(16'hBE00, 16'h4000, 1'b1);
        for (int i = 0; i < 4; i++) push(16'h3C00, 16'h3C00, 1'(i == 3));
      end
      begin
        repeat (40) @(negedge clk);
        check("fifo_full_stall", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        res_ready = 1'b1;
      end
    join
    wait_idle();

    // Asynchronous reset in the middle of feeding a vector.
    idle(8);
    for (int i = 0; i < 4; i++) push(16'h3C00, 16'h3C00, 1'(i == 3));
    #1 rst_n = 1'b0;
    #1 check_reset("mid");
    release_reset();
    push(16'h3C00, 16'h3C00, 1'b1);
    wait_idle();

    // Randomised vectors, gaps and consumer stalls.
    fork
      begin
        for (int v = 0; v < 20; v++) begin
          automatic int len = int'($urandom_range(1, 5));
          for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            push(tbl[$urandom_range(0, 7)], tbl[$urandom_range(0, 7)], 1'(k == len - 1));
          end
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
      end
    join
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_fp16_feeder.md
# mac_fp16_feeder

Upstream operand sequencer for the FP16 MAC stage. It buffers a stream of FP16 (A, B) pairs arriving over a valid/ready handshake. It drives one pair per cycle into the MAC's A/B inputs, and controls the MAC's active-high clear between dot products. It tracks the MAC's fixed pipeline latency and returns the final accumulator value of each vector on a result handshake.

## Interface
- LATENCY, 7: cycles from a pair being launched on mac_a/mac_b to mac_acc reflecting it.
- CLR_CYCLES, 5: cycles mac_rst is held high before each vector.
- FIFO_DEPTH, 4: input buffer entries; power of two, ≥2.

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_a  in  16  FP16 operand A.
- in_b  in  16  FP16 operand B.
- in_last  in  1  marks the last pair of a vector.
- mac_a  out  16  registered operand to MAC A.
- mac_b  out  16  registered operand to MAC B.
- mac_rst  out  1  registered active-high clear to the MAC.
- mac_acc  in  16  MAC accumulator output.
- res_valid  out  1  dot-product result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  16  captured accumulator value.
- busy  out  1  high in CLEAR, DRAIN and HOLD.

## Operation
- Reset (rst_n low, asynchronous) sets the following. state=CLEAR, clear counter=CLR_CYCLES, FIFO empty. Outputs: mac_a=mac_b=0, mac_rst=1, in_ready=0, res_valid=0, res_data=0, busy=1.
- FIFO:
  - A push occurs when in_valid && in_ready. Stored word: {in_last, in_a, in_b}.
  - in_ready = !full, and is 0 while rst_n is low. It is independent of state, so the next vector may be buffered during DRAIN/HOLD.
  - A simultaneous push and pop when not full leaves the count unchanged.
  - A pop in the same cycle does not make a full FIFO accept that cycle.
- CLEAR:
  - mac_rst=1 and mac_a=mac_b=0.
  - The counter decrements each cycle. When it reaches 0, mac_rst is deasserted and state goes to FEED.
- FEED:
  - Each cycle with the FIFO non-empty, pop one entry and register it onto mac_a/mac_b.
  - With the FIFO empty, drive mac_a=mac_b=0. A zero product leaves the accumulator unchanged, so gaps are legal.
  - Popping an entry with last=1 loads the drain counter with LATENCY and moves to DRAIN.
- DRAIN:
  - mac_a=mac_b=0 and no pops.
  - When the counter expires, capture mac_acc into res_data, set res_valid=1 and go to HOLD.
- HOLD:
  - res_valid and res_data are stable until res_valid && res_ready.
  - On that handshake: res_valid=0, reload the clear counter, mac_rst=1, state=CLEAR.
- Vectors are single-element or longer. A vector whose first pair has last=1 is legal.

## Timing
- Launch edge E: the rising edge that registers the last pair onto mac_a/mac_b.
- res_data is sampled from mac_acc at edge E+LATENCY. res_valid rises on that same edge.
- Input-to-MAC latency is 1 cycle minimum: push at edge P, launch no earlier than P+1. An empty FIFO produces no combinational bypass.
- Throughput is one pair per cycle in FEED.
- Per-vector overhead: CLR_CYCLES + LATENCY + 1 + HOLD wait.
- mac_rst rises on the edge after the result handshake. It stays high for exactly CLR_CYCLES cycles.
- res_ready high at the edge res_valid rises: the handshake completes on the next edge, so res_valid is high for at least 1 cycle.
- rst_n asserted mid-vector: everything returns to reset values immediately. FIFO contents are discarded and the partial result is never presented.

## Test plan
- Push (3C00,3C00,last=0), (4000,4000,last=1) back-to-back after reset. Required:
  - res_valid rises exactly LATENCY edges after the second launch, with res_data=4500.
  - mac_rst is high for exactly 5 cycles afterwards.
- Push (BE00,4000,last=1), then hold res_ready low for 10 cycles. Required: res_data=C200 is stable with res_valid high throughout, and busy=1.
- Push four (3C00,3C00) pairs, last on the 4th. Required: four consecutive launches, then res_data=4400.
- Push (3C00,3C00), idle 3 cycles, push (4500,0000), idle, push (3C00,3C00,last). Required: zero pairs are driven during the gaps, and res_data=4000.
- Hold res_ready low with two complete vectors pushed. Required:
  - in_ready falls once FIFO_DEPTH entries are buffered, and no entry is lost.
  - Results arrive in order: 4500 then C200.
- Pulse rst_n low during FEED of a 4-element vector. Required:
  - All outputs take reset values asynchronously, and the FIFO is empty.
  - A subsequent vector (3C00,3C00,last) yields res_data=3C00.
